// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and phase generator for the five-phase
// multicycle core (F, R, X, M, W). Owns the one-hot phase bus, the fetch PC,
// a circular return-address stack and the exception PC.
module pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter int               ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0] RESET_VEC  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h80),
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             stall,
    input  logic             ct_taken,
    input  logic [WIDTH-1:0] ct_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc,
    input  logic             eret,
    output logic [4:0]       phase,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    // One-hot phase encodings, bit0 = F
    localparam logic [4:0] PH_F = 5'b00001;
    localparam logic [4:0] PH_R = 5'b00010;
    localparam logic [4:0] PH_X = 5'b00100;
    localparam logic [4:0] PH_M = 5'b01000;
    localparam logic [4:0] PH_W = 5'b10000;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] STEP      = {{(WIDTH-1){1'b0}}, 1'b1} << ALIGN_BITS;

    // Clear the low ALIGN_BITS of an address
    function automatic logic [WIDTH-1:0] align_f(input logic [WIDTH-1:0] addr);
        return (addr >> ALIGN_BITS) << ALIGN_BITS;
    endfunction

    localparam logic [WIDTH-1:0] RESET_PC = align_f(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC   = align_f(EXC_VEC);

    // State registers
    logic [4:0]       phase_r;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] epc_r;
    logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] sp_r;       // index of the current top entry
    logic [CNT_W-1:0] cnt_r;      // number of valid entries
    logic             ras_err_r;

    // Next-state values
    logic [4:0]       phase_s;
    logic [WIDTH-1:0] pc_s;
    logic [WIDTH-1:0] epc_s;
    logic [PTR_W-1:0] sp_s;
    logic [CNT_W-1:0] cnt_s;
    logic             ras_err_s;
    logic             push_s;
    logic [PTR_W-1:0] push_idx_s;
    logic [WIDTH-1:0] seq_pc_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_ok_s;

    assign seq_pc_s = pc_r + STEP;     // wraps modulo 2**WIDTH, carry dropped
    assign empty_s  = (cnt_r == {CNT_W{1'b0}});
    assign full_s   = (cnt_r == CNT_FULL);

    // Next phase, PC, EPC and return-stack bookkeeping
    always_comb begin
        phase_s    = phase_r;
        pc_s       = pc_r;
        epc_s      = epc_r;
        sp_s       = sp_r;
        cnt_s      = cnt_r;
        ras_err_s  = 1'b0;
        push_s     = 1'b0;
        push_idx_s = sp_r;
        pop_ok_s   = 1'b0;
        if (exc) begin
            // Exception wins over stall and every W-phase request
            phase_s = PH_F;
            pc_s    = EXC_PC;
            epc_s   = pc_r;
        end else if (stall) begin
            phase_s = phase_r;
            pc_s    = pc_r;
        end else begin
            // Rotate; any non-one-hot value recovers to F
            case (phase_r)
                PH_F:    phase_s = PH_R;
                PH_R:    phase_s = PH_X;
                PH_X:    phase_s = PH_M;
                PH_M:    phase_s = PH_W;
                PH_W:    phase_s = PH_F;
                default: phase_s = PH_F;
            endcase
            if (phase_r == PH_W) begin
                if (eret) begin
                    pc_s = epc_r;
                end else begin
                    pop_ok_s = ret && !empty_s;
                    if (ret) begin
                        if (!empty_s) begin
                            pc_s = ras_mem_r[sp_r];
                        end else begin
                            pc_s      = seq_pc_s;
                            ras_err_s = 1'b1;
                        end
                    end else if (ct_taken) begin
                        pc_s = align_f(ct_target);
                    end else begin
                        pc_s = seq_pc_s;
                    end
                    // Pop happens before push; pop+push rewrites the top slot
                    case ({call, pop_ok_s})
                        2'b10: begin
                            push_s     = 1'b1;
                            push_idx_s = sp_r + PTR_ONE;
                            sp_s       = sp_r + PTR_ONE;
                            cnt_s      = full_s ? cnt_r : cnt_r + CNT_ONE;
                        end
                        2'b01: begin
                            sp_s  = sp_r - PTR_ONE;
                            cnt_s = cnt_r - CNT_ONE;
                        end
                        2'b11: begin
                            push_s     = 1'b1;
                            push_idx_s = sp_r;
                        end
                        default: begin
                            push_s = 1'b0;
                        end
                    endcase
                end
            end else begin
                pc_s = pc_r;
            end
        end
    end

    // State update with asynchronous reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_r   <= PH_F;
            pc_r      <= RESET_PC;
            epc_r     <= {WIDTH{1'b0}};
            sp_r      <= {PTR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ras_err_r <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            phase_r   <= phase_s;
            pc_r      <= pc_s;
            epc_r     <= epc_s;
            sp_r      <= sp_s;
            cnt_r     <= cnt_s;
            ras_err_r <= ras_err_s;
            if (push_s) begin
                ras_mem_r[push_idx_s] <= seq_pc_s;
            end else begin
                ras_mem_r[push_idx_s] <= ras_mem_r[push_idx_s];
            end
        end
    end

    assign phase     = phase_r;
    assign pc        = pc_r;
    assign epc       = epc_r;
    assign ras_err   = ras_err_r;
    assign ras_empty = empty_s;
    assign ras_full  = full_s;

endmodule
